dyn_phase_seq: RTL and testbench

DYN_PHASE_SEQ -- requirements
Module: dyn_phase_seq

---
 rtl/dyn_phase_seq.sv | 182 ++++++++++++++++++
 tb/tb_dyn_phase_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dyn_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : dyn_phase_seq
// Description : Sequences dynamic PLL phase-shift steps (PHASESTEP/PHASEDONE
//               handshake). Optional WAIT timeout under DYN_PHASE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dyn_phase_seq #(
  parameter int CNT_W       = 4,
  parameter int STEP_W      = 8,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              CLK50M,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_UPDN,
  input  logic [CNT_W-1:0]  REQ_COUNTER,
  input  logic [STEP_W-1:0] REQ_STEPS,
  input  logic              PHASEDONE,
  output logic [CNT_W-1:0]  PHASECOUNTERSELECT,
  output logic              PHASEUPDOWN,
  output logic              PHASESTEP,
  output logic              BUSY,
  output logic              DONE,
  output logic [STEP_W-1:0] STEPS_DONE,
  output logic              ERR_TIMEOUT
);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_setup   = 3'd1;
  localparam logic [2:0] c_step    = 3'd2;
  localparam logic [2:0] c_wait_lo = 3'd3;
  localparam logic [2:0] c_wait_hi = 3'd4;
  localparam logic [2:0] c_next    = 3'd5;
  localparam logic [2:0] c_finish  = 3'd6;

  localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_CYC - 1);

  logic [2:0]        r_state;
  logic [3:0]        r_hold;
  logic              r_updn_lat;
  logic [CNT_W-1:0]  r_cnt_lat;
  logic [STEP_W-1:0] r_steps;
  logic [STEP_W-1:0] r_steps_done;
  logic [CNT_W-1:0]  r_cntsel;
  logic              r_phupdn;
  logic              r_phstep;
  logic              r_done;
  logic              w_accept;
  logic              w_timeout;
  logic [STEP_W:0]   w_done_inc;

  // Ready is withheld during the DONE cycle so a new request lands after it.
  assign REQ_READY  = (r_state == c_idle) && !r_done;
  assign w_accept   = REQ_VALID && REQ_READY;
  // One extra bit keeps the compare against the request count from wrapping.
  assign w_done_inc = {1'b0, r_steps_done} + {{STEP_W{1'b0}}, 1'b1};

  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= c_idle;
      r_hold       <= '0;
      r_updn_lat   <= 1'b0;
      r_cnt_lat    <= '0;
      r_steps      <= '0;
      r_steps_done <= '0;
      r_cntsel     <= '0;
      r_phupdn     <= 1'b0;
      r_phstep     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_updn_lat   <= REQ_UPDN;
            r_cnt_lat    <= REQ_COUNTER;
            r_steps      <= REQ_STEPS;
            r_steps_done <= '0;
            if (REQ_STEPS == '0) begin
              r_state <= c_finish;
            end else begin
              r_state  <= c_setup;
              r_cntsel <= REQ_COUNTER;
              r_phupdn <= REQ_UPDN;
            end
          end
        end
        c_setup: begin
          r_state  <= c_step;
          r_phstep <= 1'b1;
          r_hold   <= '0;
        end
        c_step: begin
          if (r_hold == c_HOLD_LAST) begin
            r_phstep <= 1'b0;
            r_state  <= c_wait_lo;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        c_wait_lo: begin
          if (w_timeout) begin
            r_state  <= c_finish;
            r_phupdn <= 1'b0;
          end else if (!PHASEDONE) begin
            r_state <= c_wait_hi;
          end
        end
        c_wait_hi: begin
          if (w_timeout) begin
            r_state  <= c_finish;
            r_phupdn <= 1'b0;
          end else if (PHASEDONE) begin
            r_state  <= c_next;
            r_phupdn <= 1'b0;
          end
        end
        c_next: begin
          r_steps_done <= w_done_inc[STEP_W-1:0];
          if (w_done_inc < {1'b0, r_steps}) begin
            r_state  <= c_setup;
            r_cntsel <= r_cnt_lat;
            r_phupdn <= r_updn_lat;
          end else begin
            r_state <= c_finish;
          end
        end
        c_finish: begin
          r_done  <= 1'b1;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef DYN_PHASE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_in_wait;

  assign w_in_wait = (r_state == c_wait_lo) || (r_state == c_wait_hi);
  assign w_timeout = w_in_wait && (r_to_cnt == c_TO_LAST);

  // Counter restarts for every step; it only runs while handshaking.
  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_in_wait ? r_to_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ERR_TIMEOUT = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC == 0);
  assign w_timeout    = 1'b0;
  assign ERR_TIMEOUT  = 1'b0;
`endif

  assign PHASECOUNTERSELECT = r_cntsel;
  assign PHASEUPDOWN        = r_phupdn;
  assign PHASESTEP          = r_phstep;
  assign BUSY               = (r_state != c_idle);
  assign DONE               = r_done;
  assign STEPS_DONE         = r_steps_done;

endmodule
`default_nettype wire

// File: tb/tb_dyn_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dyn_phase_seq
// Description : Directed self-checking bench for dyn_phase_seq with a PLL model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dyn_phase_seq;

  localparam int CNT_W = 4;
  localparam int STEP_W = 8;
  localparam int HOLD = 2;
  localparam int TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_updn = 1'b0;
  logic [CNT_W-1:0]  req_counter = '0;
  logic [STEP_W-1:0] req_steps = '0;
  logic              phasedone;
  logic [CNT_W-1:0]  phcntsel;
  logic              phupdn;
  logic              phstep;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_done;
  logic              err_to;

  logic pll_auto = 1'b1;
  logic model_done = 1'b1;
  logic man_done = 1'b1;
  assign phasedone = pll_auto ? model_done : man_done;

  int checks = 0;
  int errors = 0;

  // Monitor accumulators (written only by the monitor)
  int pulses = 0, width_bad = 0, updn_bad = 0, setup_bad = 0, done_cnt = 0;
  int cur_w = 0;
  logic prev_step = 1'b0, prev_updn = 1'b0;
  logic [CNT_W-1:0] prev_sel = '0;
  logic exp_updn = 1'b0;
  logic [CNT_W-1:0] exp_sel = '0;

  always #10 clk = ~clk;

  dyn_phase_seq #(
    .CNT_W(CNT_W), .STEP_W(STEP_W), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK50M(clk), .RESET_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_UPDN(req_updn),
    .REQ_COUNTER(req_counter), .REQ_STEPS(req_steps), .PHASEDONE(phasedone),
    .PHASECOUNTERSELECT(phcntsel), .PHASEUPDOWN(phupdn), .PHASESTEP(phstep),
    .BUSY(busy), .DONE(done), .STEPS_DONE(steps_done), .ERR_TIMEOUT(err_to)
  );

  // PLL model: PHASEDONE falls 2 cycles after PHASESTEP rises, returns 5 later.
  initial begin
    forever begin
      @(posedge phstep);
      if (pll_auto) begin
        repeat (2) @(posedge clk);
        #1 model_done = 1'b0;
        repeat (5) @(posedge clk);
        #1 model_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (phstep) begin
      cur_w = cur_w + 1;
      if (phupdn !== exp_updn || phcntsel !== exp_sel) updn_bad = updn_bad + 1;
      if (!prev_step && (prev_updn !== exp_updn || prev_sel !== exp_sel))
        setup_bad = setup_bad + 1;
    end else if (cur_w != 0) begin
      pulses = pulses + 1;
      if (cur_w != HOLD) width_bad = width_bad + 1;
      cur_w = 0;
    end
    if (done) done_cnt = done_cnt + 1;
    prev_step = phstep;
    prev_updn = phupdn;
    prev_sel  = phcntsel;
  end

  task automatic send(input logic u, input logic [CNT_W-1:0] c, input logic [STEP_W-1:0] s);
    @(negedge clk);
    req_updn = u; req_counter = c; req_steps = s; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, busy, done, phstep, phupdn} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctl: got %b expected 10000", {req_ready, busy, done, phstep, phupdn});
    end
    checks++;
    if (phcntsel !== '0 || steps_done !== '0 || err_to !== 1'b0) begin
      errors++; $display("FAIL reset_data: sel=%0d steps_done=%0d err=%b expected 0/0/0", phcntsel, steps_done, err_to);
    end
  endtask

  task automatic test_basic;
    int p0, w0, u0, s0, d0;
    bit seen;
    pll_auto = 1'b1; exp_updn = 1'b1; exp_sel = 4'd2;
    p0 = pulses; w0 = width_bad; u0 = updn_bad; s0 = setup_bad; d0 = done_cnt;
    send(1'b1, 4'd2, 8'd3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy: busy=%b ready=%b expected 1/0", busy, req_ready);
    end
    wait_done(200, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_done: DONE not seen, expected within 200 cycles"); end
    checks++;
    if (steps_done !== 8'd3) begin errors++; $display("FAIL basic_steps_done: got %0d expected 3", steps_done); end
    checks++;
    if (pulses - p0 != 3) begin errors++; $display("FAIL basic_pulses: got %0d expected 3", pulses - p0); end
    checks++;
    if (width_bad != w0 || updn_bad != u0 || setup_bad != s0) begin
      errors++; $display("FAIL basic_pulse_shape: width/updn/setup bad %0d/%0d/%0d expected 0", width_bad - w0, updn_bad - u0, setup_bad - s0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_one_done: done pulses %0d busy %b expected 1/0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_zero_steps;
    int p0;
    p0 = pulses;
    send(1'b1, 4'd4, 8'd0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL zero_finish: busy=%b done=%b expected 1/0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b ready=%b expected 1/0/0", done, busy, req_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || pulses != p0 || steps_done !== 8'd0) begin
      errors++; $display("FAIL zero_after: done=%b ready=%b pulses=%0d steps_done=%0d expected 0/1/0/0", done, req_ready, pulses - p0, steps_done);
    end
  endtask

  task automatic test_back_to_back;
    int p0, u0, ready_bad;
    bit seen;
    ready_bad = 0; seen = 1'b0;
    pll_auto = 1'b1; exp_updn = 1'b0; exp_sel = 4'd3;
    p0 = pulses; u0 = updn_bad;
    @(negedge clk);
    req_updn = 1'b0; req_counter = 4'd3; req_steps = 8'd1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_updn = 1'b1; req_counter = 4'd5; req_steps = 8'd2;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) ready_bad++;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || ready_bad != 0) begin
      errors++; $display("FAIL b2b_first: done_seen=%0d ready_high_cycles=%0d expected 1/0", seen, ready_bad);
    end
    checks++;
    if (steps_done !== 8'd1 || pulses - p0 != 1) begin
      errors++; $display("FAIL b2b_first_steps: steps_done=%0d pulses=%0d expected 1/1", steps_done, pulses - p0);
    end
    exp_updn = 1'b1; exp_sel = 4'd5; p0 = pulses;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %b expected 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done(200, seen);
    checks++;
    if (!seen || steps_done !== 8'd2 || pulses - p0 != 2 || updn_bad != u0) begin
      errors++; $display("FAIL b2b_second: done=%0d steps_done=%0d pulses=%0d updn_bad=%0d expected 1/2/2/0", seen, steps_done, pulses - p0, updn_bad - u0);
    end
  endtask

  task automatic test_max_steps;
    int p0, hi_cnt, wrap;
    logic [STEP_W-1:0] prev;
    bit seen;
    pll_auto = 1'b1; exp_updn = 1'b0; exp_sel = 4'd1;
    p0 = pulses; hi_cnt = 0; wrap = 0; prev = '0; seen = 1'b0;
    send(1'b0, 4'd1, 8'd255);
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (phupdn !== 1'b0) hi_cnt++;
      if (steps_done < prev) wrap++;
      prev = steps_done;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || steps_done !== 8'd255) begin
      errors++; $display("FAIL max_steps_done: done=%0d steps_done=%0d expected 1/255", seen, steps_done);
    end
    checks++;
    if (pulses - p0 != 255 || wrap != 0 || hi_cnt != 0) begin
      errors++; $display("FAIL max_steps_shape: pulses=%0d wraps=%0d updn_high=%0d expected 255/0/0", pulses - p0, wrap, hi_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    bit seen;
    pll_auto = 1'b0; man_done = 1'b1; seen = 1'b0;
    exp_updn = 1'b1; exp_sel = 4'd6;
    send(1'b1, 4'd6, 8'd5);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (phstep) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_step: PHASESTEP not seen, expected 1"); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (phstep !== 1'b0 || busy !== 1'b0 || phupdn !== 1'b0 || phcntsel !== '0 || steps_done !== '0 || done !== 1'b0 || err_to !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: step=%b busy=%b updn=%b sel=%0d sd=%0d done=%b err=%b expected all 0",
                         phstep, busy, phupdn, phcntsel, steps_done, done, err_to);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    p0 = pulses;
    repeat (20) @(negedge clk);
    checks++;
    if (pulses != p0 || phstep !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_release: pulses=%0d step=%b busy=%b ready=%b expected 0/0/0/1", pulses - p0, phstep, busy, req_ready);
    end
  endtask

  task automatic test_timeout;
    bit seen, got;
    int k_err, k_done;
    pll_auto = 1'b0; man_done = 1'b1; seen = 1'b0;
    exp_updn = 1'b0; exp_sel = 4'd2;
    send(1'b0, 4'd2, 8'd3);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (phstep) seen = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!phstep) got = 1'b1;
    end
    checks++;
    if (!seen || !got) begin errors++; $display("FAIL to_step: step seen=%0d fell=%0d expected 1/1", seen, got); end
`ifdef DYN_PHASE_TIMEOUT_EN
    k_err = -1; k_done = -1;
    for (int k = 1; k <= 40 && k_done < 0; k++) begin
      @(negedge clk);
      if (err_to && k_err < 0) k_err = k;
      if (done) k_done = k;
    end
    checks++;
    if (k_err != TO_CYC) begin errors++; $display("FAIL to_err_time: got %0d expected %0d", k_err, TO_CYC); end
    checks++;
    if (k_done < TO_CYC || k_done > TO_CYC + 1 || steps_done !== 8'd0) begin
      errors++; $display("FAIL to_done: done at %0d steps_done=%0d expected %0d..%0d/0", k_done, steps_done, TO_CYC, TO_CYC + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_to !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_sticky: err=%b busy=%b expected 1/0", err_to, busy);
    end
    send(1'b0, 4'd2, 8'd0);
    @(negedge clk);
    checks++;
    if (err_to !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", err_to); end
    wait_done(10, got);
`else
    k_err = 0; k_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err_to) k_err++;
      if (done) k_done++;
    end
    checks++;
    if (k_err != 0 || k_done != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_wait_forever: err_cycles=%0d done=%0d busy=%b expected 0/0/1", k_err, k_done, busy);
    end
    // Release the handshake by hand so the request completes normally.
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (busy && phstep) got = 1'b1;
    end
    checks++;
    if (!got || steps_done !== 8'd1 || phupdn !== 1'b0) begin
      errors++; $display("FAIL to_resume: next_step=%0d steps_done=%0d updn=%b expected 1/1/0", got, steps_done, phupdn);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_back_to_back();
    test_max_steps();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
